// File: rtl/core_lsu_ctrl.sv
// MEM-stage load/store sequencer: drives one req/gnt/rvalid bus transaction per
// aligned access, aligns store lanes, extends load data and stalls the pipeline.
module core_lsu_ctrl #(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        read_type_i,
  input  logic [1:0]        write_type_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [DATA_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [7:0]        bus_strb_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t            state;
  logic [7:0]        tmo_cnt;
  logic [2:0]        rtype_q;
  logic [2:0]        lane_q;

  logic              access;
  logic              aligned;
  logic [1:0]        size_code;
  logic [2:0]        lane;
  logic [7:0]        strb;
  logic              timeout_hit;
  logic [DATA_W-1:0] shifted_rdata;
  logic [DATA_W-1:0] ext_rdata;

  // Size code 0..3 = 1/2/4/8 bytes; read type 111 shares LD's low bits.
  always_comb begin
    access    = mem_read_i | mem_write_i;
    lane      = addr_i[2:0];
    size_code = mem_read_i ? read_type_i[1:0] : write_type_i;
    aligned   = 1'b1;
    strb      = 8'hFF;
    case (size_code)
      2'd0: begin aligned = 1'b1;             strb = 8'h01 << lane; end
      2'd1: begin aligned = ~lane[0];         strb = 8'h03 << lane; end
      2'd2: begin aligned = (lane[1:0] == 2'b00); strb = 8'h0F << lane; end
      default: begin aligned = (lane == 3'b000); strb = 8'hFF; end
    endcase

    stall_o    = 1'b0;
    misalign_o = 1'b0;
    case (state)
      IDLE: begin
        stall_o    = access & aligned;
        misalign_o = access & ~aligned;
      end
      REQ, WAIT_R: stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase

    timeout_hit = (tmo_cnt == 8'(TIMEOUT - 1));
  end

  always_comb begin
    shifted_rdata = bus_rdata_i >> {lane_q, 3'b000};
    ext_rdata     = shifted_rdata;
    case (rtype_q)
      3'b000: ext_rdata = {{(DATA_W-8){shifted_rdata[7]}}, shifted_rdata[7:0]};
      3'b001: ext_rdata = {{(DATA_W-16){shifted_rdata[15]}}, shifted_rdata[15:0]};
      3'b010: ext_rdata = {{(DATA_W-32){shifted_rdata[31]}}, shifted_rdata[31:0]};
      3'b100: ext_rdata = {{(DATA_W-8){1'b0}}, shifted_rdata[7:0]};
      3'b101: ext_rdata = {{(DATA_W-16){1'b0}}, shifted_rdata[15:0]};
      3'b110: ext_rdata = {{(DATA_W-32){1'b0}}, shifted_rdata[31:0]};
      default: ext_rdata = shifted_rdata;
    endcase
  end

  // The timeout counter keeps running from REQ into WAIT_R, so TIMEOUT bounds the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tmo_cnt       <= 8'd0;
      rtype_q       <= 3'b000;
      lane_q        <= 3'b000;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      bus_err_o     <= 1'b0;
      bus_req_o     <= 1'b0;
      bus_we_o      <= 1'b0;
      bus_addr_o    <= '0;
      bus_wdata_o   <= '0;
      bus_strb_o    <= 8'h00;
    end else begin
      rdata_valid_o <= 1'b0;
      bus_err_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (access && aligned) begin
            state       <= REQ;
            tmo_cnt     <= 8'd0;
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_write_i;
            bus_addr_o  <= {addr_i[DATA_W-1:3], 3'b000};
            bus_wdata_o <= wdata_i << {lane, 3'b000};
            bus_strb_o  <= strb;
            rtype_q     <= read_type_i;
            lane_q      <= lane;
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            state     <= bus_we_o ? DONE : WAIT_R;
          end else if (timeout_hit) begin
            bus_req_o <= 1'b0;
            bus_err_o <= 1'b1;
            rdata_o   <= '0;
            state     <= DONE;
          end
        end
        WAIT_R: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (bus_rvalid_i) begin
            rdata_o       <= ext_rdata;
            rdata_valid_o <= 1'b1;
            state         <= DONE;
          end else if (timeout_hit) begin
            bus_err_o <= 1'b1;
            rdata_o   <= '0;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
